// File: rtl/axi4s_stream_checker_pkg.sv
// Shared types for the AXI4-Stream checker: FSM states, mode
// encodings, per-beat error bundle, LFSR taps and seeds.
package axi4s_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_STOPPING = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    DM_COUNTER = 2'd0,
    DM_RANDOM  = 2'd1,
    DM_CUSTOM  = 2'd2
  } data_mode_e;

  typedef enum logic {
    TM_COUNTER = 1'b0,
    TM_RANDOM  = 1'b1
  } tid_mode_e;

  // Fibonacci tap masks: bit (e-1) set for each exponent e.
  localparam logic [15:0] LFSR16_POLY = 16'hB400;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;
  localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR32_SEED = 32'h0000_0001;

  typedef struct packed {
    logic data;
    logic strb;
    logic tid;
    logic last;
  } beat_err_t;

endpackage

// File: rtl/axi4s_chk_lfsr.sv
// Shift-left Fibonacci LFSR with step enable and reseed.
// Ports: clk, rst_n, step, reseed, q (current value).
module axi4s_chk_lfsr
  import axi4s_stream_checker_pkg::*;
#(
  parameter int unsigned        WIDTH_P = 16,
  parameter logic [WIDTH_P-1:0] POLY_P  = '0,
  parameter logic [WIDTH_P-1:0] SEED_P  = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               reseed,
  output logic [WIDTH_P-1:0] q
);

  logic fb;

  assign fb = ^(q & POLY_P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_P;
    end else if (reseed) begin
      q <= SEED_P;
    end else if (step) begin
      q <= {q[WIDTH_P-2:0], fb};
    end
  end

endmodule

// File: rtl/axi4s_stream_checker.sv
// AXI4-Stream sink that checks data/tid/tlast/strobes and counts.
// Ports: clk/rst_n, cr_* control, axi4s_* stream, sr_* status, irq_error.
module axi4s_stream_checker
  import axi4s_stream_checker_pkg::*;
#(
  parameter int TDATA_WIDTH_P = 32,
  parameter int TSTRB_WIDTH_P = TDATA_WIDTH_P / 8,
  parameter int TID_WIDTH_P   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cr_enable,
  input  logic                     cr_clear,
  input  logic [1:0]               cr_tdata_type,
  input  logic                     cr_tid_type,
  input  logic [15:0]              cr_pkt_len,
  input  logic                     cr_ready_mode,
  input  logic                     axi4s_i_tvalid,
  output logic                     axi4s_o_tready,
  input  logic [TDATA_WIDTH_P-1:0] axi4s_i_tdata,
  input  logic [TSTRB_WIDTH_P-1:0] axi4s_i_tstrb,
  input  logic [TSTRB_WIDTH_P-1:0] axi4s_i_tkeep,
  input  logic [TID_WIDTH_P-1:0]   axi4s_i_tid,
  input  logic                     axi4s_i_tlast,
  output logic [31:0]              sr_beat_count,
  output logic [31:0]              sr_pkt_count,
  output logic [15:0]              sr_error_count,
  output logic [31:0]              sr_first_err_beat,
  output logic [1:0]               sr_state,
  output logic                     irq_error
);

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Assert asynchronously, release on the second clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  chk_state_e state_q;
  chk_state_e state_nxt;

  logic                     tready_q;
  logic                     tready_d;
  logic                     beat;
  logic [15:0]              bip_q;
  logic [15:0]              bip_nxt;
  logic [TDATA_WIDTH_P-1:0] exp_cnt_q;
  logic [TDATA_WIDTH_P-1:0] rnd_data;
  logic [TDATA_WIDTH_P-1:0] exp_data;
  logic [31:0]              beat_cnt_q;
  logic [31:0]              pkt_cnt_q;
  logic [15:0]              err_cnt_q;
  logic [31:0]              first_q;
  logic                     irq_q;
  logic [15:0]              lfsr16_q;
  logic [31:0]              lfsr32_q;
  logic                     unused_lfsr;
  beat_err_t                berr;
  logic                     beat_err;

  // A beat coinciding with cr_clear is dropped entirely.
  assign beat = axi4s_i_tvalid & tready_q & ~cr_clear;

  axi4s_chk_lfsr #(
    .WIDTH_P (16),
    .POLY_P  (LFSR16_POLY),
    .SEED_P  (LFSR16_SEED)
  ) u_lfsr16 (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .step   (state_q != ST_IDLE),
    .reseed (cr_clear),
    .q      (lfsr16_q)
  );

  axi4s_chk_lfsr #(
    .WIDTH_P (32),
    .POLY_P  (LFSR32_POLY),
    .SEED_P  (LFSR32_SEED)
  ) u_lfsr32 (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .step   (beat),
    .reseed (cr_clear),
    .q      (lfsr32_q)
  );

  assign unused_lfsr = ^lfsr16_q[15:2];

  for (genvar g = 0; g < TDATA_WIDTH_P; g++) begin : g_rep
    assign rnd_data[g] = lfsr32_q[g % 32];
  end

  always_comb begin
    bip_nxt = bip_q;
    if (cr_clear) begin
      bip_nxt = '0;
    end else if (beat) begin
      bip_nxt = axi4s_i_tlast ? 16'd0 : bip_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Packet boundary is judged after this cycle's beat.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cr_enable) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!cr_enable) begin
          state_nxt = (bip_nxt == '0) ? ST_IDLE : ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (cr_enable) begin
          state_nxt = ST_ACTIVE;
        end else if (beat && axi4s_i_tlast) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tready_d = (state_nxt != ST_IDLE) &
               (~cr_ready_mode | (lfsr16_q[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= tready_d;
    end
  end

  // Custom (and reserved) mode compares tdata with itself.
  always_comb begin
    exp_data = axi4s_i_tdata;
    unique case (1'b1)
      (cr_tdata_type == DM_COUNTER): exp_data = exp_cnt_q;
      (cr_tdata_type == DM_RANDOM):  exp_data = rnd_data;
      default: ;
    endcase
  end

  always_comb begin
    berr.data = (axi4s_i_tdata != exp_data);
    berr.strb = (axi4s_i_tstrb != '1) | (axi4s_i_tkeep != '1);
    berr.tid  = (cr_tid_type == TM_COUNTER) &
                (axi4s_i_tid != pkt_cnt_q[TID_WIDTH_P-1:0]);
    berr.last = (cr_pkt_len != '0) &
                (axi4s_i_tlast != (bip_q == cr_pkt_len - 16'd1));
  end

  assign beat_err = |berr;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      bip_q      <= '0;
      exp_cnt_q  <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      irq_q      <= 1'b0;
    end else if (cr_clear) begin
      bip_q      <= '0;
      exp_cnt_q  <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      first_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      bip_q <= bip_nxt;
      irq_q <= beat & beat_err;
      if (beat) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
        exp_cnt_q  <= exp_cnt_q + TDATA_WIDTH_P'(1);
        if (axi4s_i_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        if (beat_err) begin
          if (err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
          if (err_cnt_q == 16'd0) first_q <= beat_cnt_q;
        end
      end
    end
  end

  assign axi4s_o_tready    = tready_q;
  assign sr_beat_count     = beat_cnt_q;
  assign sr_pkt_count      = pkt_cnt_q;
  assign sr_error_count    = err_cnt_q;
  assign sr_first_err_beat = first_q;
  assign sr_state          = state_q;
  assign irq_error         = irq_q;

endmodule

// File: tb/tb_axi4s_stream_checker.sv
// Randomized bench for axi4s_stream_checker with a behavioural model
// compared every cycle, plus scenario literals.
module tb_axi4s_stream_checker;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cr_enable = 1'b0;
  logic          cr_clear = 1'b0;
  logic [1:0]    cr_tdata_type = 2'd0;
  logic          cr_tid_type = 1'b0;
  logic [15:0]   cr_pkt_len = 16'd0;
  logic          cr_ready_mode = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [DW-1:0] tdata = '0;
  logic [SW-1:0] tstrb = '1;
  logic [SW-1:0] tkeep = '1;
  logic [IW-1:0] tid = '0;
  logic          tlast = 1'b0;
  logic [31:0]   beat_cnt;
  logic [31:0]   pkt_cnt;
  logic [15:0]   err_cnt;
  logic [31:0]   first_err;
  logic [1:0]    st;
  logic          irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4s_stream_checker #(
    .TDATA_WIDTH_P (DW),
    .TSTRB_WIDTH_P (SW),
    .TID_WIDTH_P   (IW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cr_enable         (cr_enable),
    .cr_clear          (cr_clear),
    .cr_tdata_type     (cr_tdata_type),
    .cr_tid_type       (cr_tid_type),
    .cr_pkt_len        (cr_pkt_len),
    .cr_ready_mode     (cr_ready_mode),
    .axi4s_i_tvalid    (tvalid),
    .axi4s_o_tready    (tready),
    .axi4s_i_tdata     (tdata),
    .axi4s_i_tstrb     (tstrb),
    .axi4s_i_tkeep     (tkeep),
    .axi4s_i_tid       (tid),
    .axi4s_i_tlast     (tlast),
    .sr_beat_count     (beat_cnt),
    .sr_pkt_count      (pkt_cnt),
    .sr_error_count    (err_cnt),
    .sr_first_err_beat (first_err),
    .sr_state          (st),
    .irq_error         (irq)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr32_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // Behavioural model state.
  logic [31:0]   m_beat, m_pkt, m_first, m_lfsr;
  logic [15:0]   m_err, m_bip;
  logic [DW-1:0] m_cnt, m_ed;
  logic [1:0]    m_st;
  logic          m_irq, m_acc, m_e, m_rm;
  logic          rdy_s = 1'b0;
  logic          acc_flag = 1'b0;
  int            irq_seen = 0;
  int            act_cyc = 0;
  int            low_cyc = 0;

  task automatic model_zero();
    m_beat = 0; m_pkt = 0; m_first = 0; m_err = 0;
    m_bip = 0; m_cnt = 0; m_lfsr = 32'h1; m_irq = 0;
  endtask

  always @(negedge clk) rdy_s = tready;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_zero();
      m_st = 0;
      acc_flag = 0;
    end else begin
      m_acc = tvalid && rdy_s && !cr_clear;
      acc_flag = m_acc;
      m_rm = cr_ready_mode;
      m_irq = 0;
      if (cr_clear) begin
        model_zero();
      end else if (m_acc) begin
        m_ed = (cr_tdata_type == 2'd1) ? m_lfsr : m_cnt;
        m_e = 0;
        if (cr_tdata_type < 2'd2 && tdata !== m_ed) m_e = 1;
        if (tstrb !== '1 || tkeep !== '1) m_e = 1;
        if (!cr_tid_type && tid !== m_pkt[IW-1:0]) m_e = 1;
        if (cr_pkt_len != 0 &&
            tlast !== (m_bip == cr_pkt_len - 16'd1)) m_e = 1;
        m_irq = m_e;
        if (m_e) begin
          if (m_err == 0) m_first = m_beat;
          if (m_err != 16'hFFFF) m_err++;
        end
        m_beat++;
        m_cnt++;
        m_lfsr = lfsr32_next(m_lfsr);
        if (tlast) begin
          m_pkt++;
          m_bip = 0;
        end else begin
          m_bip++;
        end
      end
      case (m_st)
        2'd0: if (cr_enable) m_st = 2'd1;
        2'd1: if (!cr_enable) m_st = (m_bip == 0) ? 2'd0 : 2'd2;
        2'd2: begin
          if (cr_enable) m_st = 2'd1;
          else if (m_acc && tlast) m_st = 2'd0;
        end
        default: m_st = 2'd0;
      endcase
      #1;
      chk("beat_count", beat_cnt, m_beat);
      chk("pkt_count", pkt_cnt, m_pkt);
      chk("error_count", err_cnt, m_err);
      chk("first_err_beat", first_err, m_first);
      chk("state", st, m_st);
      chk("irq_error", irq, m_irq);
      if (m_st == 0) chk("tready_idle", tready, 1'b0);
      else if (!m_rm) chk("tready_always", tready, 1'b1);
      if (irq) irq_seen++;
      if (st != 0) begin
        act_cyc++;
        if (!tready) low_cyc++;
      end
    end
  end

  // Stimulus generator: the beat the checker should see next.
  logic [DW-1:0] g_cnt;
  logic [31:0]   g_lfsr;
  logic [IW-1:0] g_pkt;
  logic [15:0]   g_bip;

  task automatic gen_reset();
    g_cnt = 0; g_lfsr = 32'h1; g_pkt = 0; g_bip = 0;
  endtask

  task automatic send(input int n, input int bad_data,
                      input int bad_strb, input int early_last,
                      input int gap_max);
    for (int i = 0; i < n; i++) begin
      int  tmo;
      logic lst;
      lst = (cr_pkt_len != 0) && (g_bip == cr_pkt_len - 16'd1);
      if (i == early_last) lst = 1;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      tvalid = 1;
      tdata = (cr_tdata_type == 2'd1) ? g_lfsr : g_cnt;
      if (i == bad_data) tdata = 32'hDEAD;
      tstrb = (i == bad_strb) ? 4'hE : 4'hF;
      tkeep = 4'hF;
      tid = cr_tid_type ? IW'($urandom) : g_pkt;
      tlast = lst;
      tmo = 0;
      do begin
        @(negedge clk);
        tmo++;
      end while (!acc_flag && tmo < 200);
      checks++;
      if (!acc_flag) begin
        failures++;
        $display("FAIL beat_accept actual=timeout required=accepted");
      end
      tvalid = 0;
      tlast = 0;
      g_cnt++;
      g_lfsr = lfsr32_next(g_lfsr);
      if (lst) begin
        g_bip = 0;
        g_pkt++;
      end else begin
        g_bip++;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    cr_clear = 1;
    @(negedge clk);
    cr_clear = 0;
    gen_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_beat"}, beat_cnt, 0);
    chk({tag, "_pkt"}, pkt_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_first"}, first_err, 0);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_tready"}, tready, 0);
  endtask

  initial begin
    int pct;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    chk("ref_lfsr32", lfsr32_next(lfsr32_next(lfsr32_next(32'h1))),
        32'hD);
    rst_n = 1;
    repeat (4) @(negedge clk);

    // Clean counter-mode stream, two packets.
    cr_pkt_len = 4; cr_tdata_type = 0; cr_tid_type = 0;
    cr_ready_mode = 0;
    gen_reset();
    irq_seen = 0;
    cr_enable = 1;
    send(8, -1, -1, -1, 0);
    cr_enable = 0;
    repeat (2) @(negedge clk);
    chk("s1_beat", beat_cnt, 8);
    chk("s1_pkt", pkt_cnt, 2);
    chk("s1_err", err_cnt, 0);
    chk("s1_irq_pulses", irq_seen, 0);
    chk("s1_state", st, 0);

    // Single corrupted data beat.
    do_clear();
    irq_seen = 0;
    cr_enable = 1;
    send(8, 5, -1, -1, 0);
    cr_enable = 0;
    repeat (2) @(negedge clk);
    chk("s2_err", err_cnt, 1);
    chk("s2_first", first_err, 5);
    chk("s2_irq_pulses", irq_seen, 1);
    chk("s2_beat", beat_cnt, 8);

    // Random data, random tid, backpressure.
    do_clear();
    cr_tdata_type = 1; cr_tid_type = 1; cr_ready_mode = 1;
    cr_pkt_len = 8;
    act_cyc = 0; low_cyc = 0;
    cr_enable = 1;
    send(1000, -1, -1, -1, 2);
    cr_enable = 0;
    pct = (act_cyc > 0) ? (low_cyc * 100) / act_cyc : 0;
    repeat (2) @(negedge clk);
    chk("s3_err", err_cnt, 0);
    chk("s3_beat", beat_cnt, 1000);
    chk("s3_pkt", pkt_cnt, 125);
    chk("s3_ready_low_pct_in_15_35", (pct >= 15 && pct <= 35), 1);

    // Stop requested mid-packet.
    do_clear();
    cr_tdata_type = 0; cr_tid_type = 0; cr_ready_mode = 0;
    cr_pkt_len = 4;
    cr_enable = 1;
    send(2, -1, -1, -1, 0);
    cr_enable = 0;
    send(1, -1, -1, -1, 0);
    chk("s4_state_stopping", st, 2);
    send(1, -1, -1, -1, 0);
    chk("s4_state_idle", st, 0);
    chk("s4_tready_low", tready, 0);
    chk("s4_pkt", pkt_cnt, 1);

    // Bad strobe and an early tlast.
    do_clear();
    irq_seen = 0;
    cr_enable = 1;
    send(7, -1, 0, 2, 0);
    cr_enable = 0;
    repeat (2) @(negedge clk);
    chk("s5_err", err_cnt, 2);
    chk("s5_first", first_err, 0);
    chk("s5_irq_pulses", irq_seen, 2);
    chk("s5_pkt", pkt_cnt, 2);

    // Clear coincident with an accepted beat.
    do_clear();
    cr_pkt_len = 0;
    cr_enable = 1;
    send(3, -1, -1, -1, 0);
    tvalid = 1;
    tdata = g_cnt;
    cr_clear = 1;
    @(negedge clk);
    cr_clear = 0;
    tvalid = 0;
    gen_reset();
    chk("s6_beat", beat_cnt, 0);
    chk("s6_pkt", pkt_cnt, 0);
    chk("s6_err", err_cnt, 0);
    chk("s6_first", first_err, 0);
    send(1, -1, -1, 0, 0);
    chk("s6_beat_after", beat_cnt, 1);
    chk("s6_err_after", err_cnt, 0);
    cr_enable = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a packet.
    cr_pkt_len = 4;
    cr_enable = 1;
    send(2, -1, -1, -1, 0);
    #2 rst_n = 0;
    #1 check_reset_outputs("s7");
    cr_enable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    gen_reset();
    cr_enable = 1;
    send(4, -1, -1, -1, 0);
    cr_enable = 0;
    repeat (2) @(negedge clk);
    chk("s7_beat", beat_cnt, 4);
    chk("s7_pkt", pkt_cnt, 1);
    chk("s7_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
